// File: rtl/gray_pkg.sv
// Shared definitions for the RGB-to-monochrome stream filter: mode encodings,
// luma weights and the reciprocal constant used for the exact divide-by-3.
package gray_pkg;

  typedef enum logic [1:0] {
    MODE_AVG    = 2'd0,
    MODE_LUMA   = 2'd1,
    MODE_THRESH = 2'd2,
    MODE_MAX    = 2'd3
  } mode_e;

  localparam int KR     = 77;
  localparam int KG     = 150;
  localparam int KB     = 29;
  localparam int KSHIFT = 8;

  typedef struct packed {
    logic [31:0] mult;
    logic [7:0]  shift;
  } recip_t;

  // x < 2^(cw+2); with shift = cw+4 the rounding error of ceil(2^s/3) stays
  // below one output LSB for every x, so floor(x*mult >> shift) == floor(x/3).
  function automatic recip_t div3_recip(input int cw);
    recip_t r;
    int     s;
    s       = cw + 4;
    r.shift = 8'(s);
    r.mult  = 32'(((64'd1 << s) + 64'd2) / 64'd3);
    return r;
  endfunction

endpackage

// File: rtl/div3_const.sv
// Combinational exact floor(x/3) for a (CW+2)-bit operand using a reciprocal
// multiply and shift.
module div3_const
  import gray_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW+1:0] x_i,
  output logic [CW-1:0] q_o
);

  localparam recip_t RC = div3_recip(CW);
  localparam int     S  = int'(RC.shift);
  localparam int     XW = CW + 2;
  localparam int     PW = XW + S;
  localparam logic [PW-1:0] M = PW'(RC.mult);

  logic [PW-1:0] prod;
  logic          unused_bits;

  assign prod = PW'(x_i) * M;
  // Quotient of a sum of three CW-bit channels always fits in CW bits.
  assign q_o         = prod[S +: CW];
  assign unused_bits = ^{prod[PW-1:S+CW], prod[S-1:0]};

endmodule

// File: rtl/gray_stream_filter.sv
// Three-stage valid/ready pipeline converting packed RGB pixels to a single
// monochrome sample: average, weighted luma, luma threshold or channel max.
module gray_stream_filter
  import gray_pkg::*;
#(
  parameter int CW        = 8,
  parameter int PIX_CNT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [3*CW-1:0]      s_pixel,
  input  logic                 s_last,
  input  logic [1:0]           mode,
  input  logic [CW-1:0]        threshold,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CW-1:0]        m_gray,
  output logic                 m_last,
  output logic [PIX_CNT_W-1:0] pix_count
);

  localparam int SW = CW + 2;
  localparam int WW = CW + 8;

  logic ready1, ready2, ready3;

  logic [CW-1:0] r_d, g_d, b_d;
  logic [SW-1:0] sum1_d;
  logic [WW-1:0] wsum1_d;
  logic [CW-1:0] max1_d;

  logic          v1_q;
  logic [SW-1:0] sum1_q;
  logic [WW-1:0] wsum1_q;
  logic [CW-1:0] max1_q;
  logic          last1_q;
  mode_e         mode1_q;
  logic [CW-1:0] thr1_q;

  logic [CW-1:0] avg2_d;
  logic [CW-1:0] luma2_d;
  logic [CW-1:0] res2_d;
  logic          v2_q;
  logic [CW-1:0] res2_q;
  logic          last2_q;
  mode_e         mode2_q;
  logic [CW-1:0] thr2_q;

  logic [CW-1:0] gray3_d;
  logic          v3_q;
  logic [CW-1:0] gray3_q;
  logic          last3_q;

  logic [PIX_CNT_W-1:0] pix_count_q;
  logic                 unused_wlo;

  // Each stage may load whenever it is empty or its content leaves this cycle.
  assign ready3 = !v3_q || m_ready;
  assign ready2 = !v2_q || ready3;
  assign ready1 = !v1_q || ready2;

  assign r_d = s_pixel[3*CW-1:2*CW];
  assign g_d = s_pixel[2*CW-1:CW];
  assign b_d = s_pixel[CW-1:0];

  assign sum1_d  = SW'(r_d) + SW'(g_d) + SW'(b_d);
  assign wsum1_d = WW'(KR) * WW'(r_d) + WW'(KG) * WW'(g_d) + WW'(KB) * WW'(b_d);

  always_comb begin
    max1_d = r_d;
    if (g_d > max1_d) max1_d = g_d;
    if (b_d > max1_d) max1_d = b_d;
  end

  div3_const #(.CW(CW)) u_div3 (
    .x_i (sum1_q),
    .q_o (avg2_d)
  );

  assign luma2_d    = wsum1_q[KSHIFT +: CW];
  assign unused_wlo = ^wsum1_q[KSHIFT-1:0];

  always_comb begin
    res2_d = luma2_d;
    case (mode1_q)
      MODE_AVG:    res2_d = avg2_d;
      MODE_LUMA:   res2_d = luma2_d;
      MODE_THRESH: res2_d = luma2_d;
      MODE_MAX:    res2_d = max1_q;
      default:     res2_d = luma2_d;
    endcase
  end

  always_comb begin
    gray3_d = res2_q;
    if (mode2_q == MODE_THRESH) gray3_d = (res2_q >= thr2_q) ? '1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      sum1_q      <= '0;
      wsum1_q     <= '0;
      max1_q      <= '0;
      last1_q     <= 1'b0;
      mode1_q     <= MODE_AVG;
      thr1_q      <= '0;
      v2_q        <= 1'b0;
      res2_q      <= '0;
      last2_q     <= 1'b0;
      mode2_q     <= MODE_AVG;
      thr2_q      <= '0;
      v3_q        <= 1'b0;
      gray3_q     <= '0;
      last3_q     <= 1'b0;
      pix_count_q <= '0;
    end else begin
      if (ready1) begin
        v1_q <= s_valid;
        if (s_valid) begin
          sum1_q  <= sum1_d;
          wsum1_q <= wsum1_d;
          max1_q  <= max1_d;
          last1_q <= s_last;
          mode1_q <= mode_e'(mode);
          thr1_q  <= threshold;
        end
      end
      if (ready2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          res2_q  <= res2_d;
          last2_q <= last1_q;
          mode2_q <= mode1_q;
          thr2_q  <= thr1_q;
        end
      end
      if (ready3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          gray3_q <= gray3_d;
          last3_q <= last2_q;
        end
      end
      if (s_valid && ready1 && !(&pix_count_q))
        pix_count_q <= pix_count_q + PIX_CNT_W'(1);
    end
  end

  assign s_ready   = ready1;
  assign m_valid   = v3_q;
  assign m_gray    = gray3_q;
  assign m_last    = last3_q;
  assign pix_count = pix_count_q;

endmodule

// File: tb/tb_gray_stream_filter.sv
// Scoreboard bench for gray_stream_filter: the driver queues expected samples
// at acceptance, a monitor pops and compares them as the DUT emits samples.
module tb_gray_stream_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_pixel;
  logic        s_last;
  logic [1:0]  mode;
  logic [7:0]  threshold;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_gray;
  logic        m_last;
  logic [23:0] pix_count;

  logic        s2_valid;
  logic        s2_ready;
  logic        m2_valid;
  logic [7:0]  m2_gray;
  logic        m2_last;
  logic [3:0]  pc2;

  always #5 clk = ~clk;

  gray_stream_filter #(.CW(8), .PIX_CNT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_pixel(s_pixel), .s_last(s_last), .mode(mode), .threshold(threshold),
    .m_valid(m_valid), .m_ready(m_ready), .m_gray(m_gray), .m_last(m_last),
    .pix_count(pix_count)
  );

  gray_stream_filter #(.CW(8), .PIX_CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .s_valid(s2_valid), .s_ready(s2_ready),
    .s_pixel(24'h0), .s_last(1'b0), .mode(2'd0), .threshold(8'h0),
    .m_valid(m2_valid), .m_ready(1'b1), .m_gray(m2_gray), .m_last(m2_last),
    .pix_count(pc2)
  );

  typedef struct {
    logic [7:0] g;
    logic       last;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   chk = 0;
  int   err = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  bit   lat_on = 0;
  bit   rnd_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_gray(input logic [23:0] p, input logic [1:0] md,
                                          input logic [7:0] th);
    int r, g, b, y, mx;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    y = (77 * r + 150 * g + 29 * b) / 256;
    mx = (r > g) ? r : g;
    mx = (mx > b) ? mx : b;
    case (md)
      2'd0:    return 8'((r + g + b) / 3);
      2'd1:    return 8'(y);
      2'd2:    return (y >= int'(th)) ? 8'hFF : 8'h00;
      default: return 8'(mx);
    endcase
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [23:0] p, input logic l, input logic [1:0] md,
                      input logic [7:0] th, input logic [7:0] e);
    bit got = 0;
    s_valid = 1'b1;
    s_pixel = p;
    s_last = l;
    mode = md;
    threshold = th;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (s_ready) begin
        q.push_back('{g: e, last: l, cyc: cyc});
        acc_cnt++;
        got = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      chk++;
      err++;
      $display("FAIL send_timeout actual no_accept required accept");
    end
  endtask

  task automatic send_m(input logic [23:0] p, input logic l, input logic [1:0] md,
                        input logic [7:0] th);
    send(p, l, md, th, ref_gray(p, md, th));
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    check("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] hold_g;
  logic       hold_l;
  bit         prev_stall = 0;

  always @(negedge clk) begin
    exp_t it;
    if (rst_n && m_valid && m_ready) begin
      if (q.size() == 0) begin
        chk++;
        err++;
        $display("FAIL unexpected_output actual %0h required none", m_gray);
      end else begin
        it = q.pop_front();
        check("gray", 32'(m_gray), 32'(it.g));
        check("last", 32'(m_last), 32'(it.last));
        if (lat_on) check("latency", 32'(cyc - it.cyc), 32'd3);
      end
    end
    if (rst_n && m_valid && !m_ready) begin
      if (prev_stall) begin
        check("hold_gray", 32'(m_gray), 32'(hold_g));
        check("hold_last", 32'(m_last), 32'(hold_l));
      end
      hold_g = m_gray;
      hold_l = m_last;
      prev_stall = 1;
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    int n2;
    int vcnt;
    logic [23:0] bp_pix[6];
    s_valid = 0; s_pixel = 0; s_last = 0; mode = 0; threshold = 0;
    m_ready = 1; s2_valid = 0;
    rst_n = 0;
    #23 rst_n = 1;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_gray", 32'(m_gray), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_pix_count", pix_count, 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: six pixels, downstream stalled for five cycles.
    for (int i = 0; i < 6; i++) bp_pix[i] = 24'($urandom);
    m_ready = 0;
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_m(bp_pix[i], i == 5, 2'd0, 8'h00);
        s_valid = 0;
        s_last = 0;
      end
      begin
        for (int i = 0; i < 100 && acc_cnt < 1; i++) @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("bp_s_ready_low", 32'(s_ready), 32'd0);
        check("bp_accepted", 32'(acc_cnt), 32'd3);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        m_ready = 1;
      end
    join
    drain();
    check("bp_pix_count", pix_count, 32'd6);

    // Mode 0 back-to-back with latency tracking.
    lat_on = 1;
    send(24'hFFFFFF, 0, 2'd0, 8'h00, 8'hFF);
    send(24'h010203, 0, 2'd0, 8'h00, 8'h02);
    send(24'h000002, 0, 2'd0, 8'h00, 8'h00);
    send(24'h7F7F80, 1, 2'd0, 8'h00, 8'h7F);
    s_valid = 0;
    drain();
    lat_on = 0;

    send(24'hFF0000, 0, 2'd1, 8'h00, 8'h4C);
    send(24'h00FF00, 0, 2'd1, 8'h00, 8'h95);
    send(24'h0000FF, 0, 2'd1, 8'h00, 8'h1C);
    send(24'hFFFFFF, 0, 2'd1, 8'h00, 8'hFF);

    // Threshold is captured per pixel; the changed level applies to the second.
    send(24'h00FF00, 0, 2'd2, 8'h80, 8'hFF);
    send(24'hFF0000, 0, 2'd2, 8'h40, 8'hFF);
    send(24'hFF0000, 0, 2'd2, 8'h80, 8'h00);

    send(24'h123456, 0, 2'd3, 8'h00, 8'h56);
    send(24'h000000, 1, 2'd3, 8'h00, 8'h00);
    s_valid = 0;
    drain();

    // Randomised traffic with random gaps and random downstream stalls.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            s_valid = 0;
            @(posedge clk);
            #1;
          end
          send_m(24'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
        end
        s_valid = 0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1;
      end
    join
    drain();

    // Reset with pixels in flight.
    m_ready = 0;
    send_m(24'h102030, 0, 2'd1, 8'h00);
    send_m(24'h405060, 0, 2'd3, 8'h00);
    s_valid = 0;
    @(posedge clk);
    #1;
    check("pre_rst_m_valid", 32'(m_valid), 32'd1);
    #2 rst_n = 0;
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_pix_count", pix_count, 32'd0);
    check("mid_rst_m_gray", 32'(m_gray), 32'd0);
    q.delete();
    #3 rst_n = 1;
    m_ready = 1;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid) vcnt++;
    end
    check("post_rst_no_output", 32'(vcnt), 32'd0);
    @(posedge clk);
    #1;

    // Saturating counter on the narrow instance.
    n2 = 0;
    s2_valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s2_ready) n2++;
      @(posedge clk);
      #1;
      if (n2 == 10 && i == 9) check("sat_count_10", 32'(pc2), 32'd10);
    end
    s2_valid = 0;
    check("sat_accepted", 32'(n2), 32'd20);
    check("sat_count", 32'(pc2), 32'd15);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/gray_stream_filter.md
Name: gray_stream_filter

Overview:
- Streaming RGB-to-monochrome converter, parametrised in channel width.
- Three-stage pipeline with valid/ready handshakes on both sides.
- Conversion mode is selected per pixel: exact average, weighted luma, binary threshold, or channel maximum.
- Sits between the pixel source (frame reader or camera front end) and the output/framebuffer writer.
- Carries an end-of-line marker alongside each pixel.

Parameters:
- CW, 8: bits per colour channel and per output sample (range 4..12).
- PIX_CNT_W, 24: width of the saturating accepted-pixel counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  block can accept an input pixel.
- s_pixel  in  3*CW  packed pixel: R = [3CW-1:2CW], G = [2CW-1:CW], B = [CW-1:0].
- s_last  in  1  last pixel of a line.
- mode  in  2  conversion mode: 0 average, 1 luma, 2 threshold, 3 max.
- threshold  in  CW  threshold level for mode 2.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts the sample.
- m_gray  out  CW  output sample.
- m_last  out  1  s_last delayed with its pixel.
- pix_count  out  PIX_CNT_W  number of accepted input pixels; saturates at all-ones.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - all stage valids = 0, so m_valid = 0; m_gray = 0; m_last = 0; pix_count = 0.
  - s_ready = 1 from the first cycle after reset release.
- Transfers: an input transfer happens when s_valid && s_ready; an output transfer happens when m_valid && m_ready.
- Input capture: mode and threshold are sampled together with the pixel at the input transfer. Changing them mid-stream affects only later pixels.
- Pipeline stage k (k = 1..3) holds valid_k. Stage k loads when its upstream has data and ready_k = !valid_k || ready_{k+1}; ready_4 = m_ready.
- s_ready = ready_1. This is combinational from m_ready through the stage valids. No other comb path exists.
- Latency: exactly 3 cycles from input transfer to m_valid when m_ready stays 1. Throughput is 1 pixel/cycle.
- Backpressure: with m_ready = 0, at most 3 pixels are held. s_ready drops once all three stages are valid. No pixel is dropped or duplicated, and order is preserved.
- m_gray, m_last and m_valid stay stable while m_valid && !m_ready.
- Stage 1 registers R, G, B, last, mode, threshold, plus:
  - sum = R+G+B, width CW+2.
  - wsum = 77R+150G+29B, width CW+8.
  - max = max(R, G, B).
- Stage 2 registers the mode result:
  - mode 0: floor(sum/3), exact for every input. Implemented as a reciprocal multiply and shift; no divider. Result < 2^CW.
  - modes 1 and 2: luma = wsum >> 8. Coefficients sum to 256, so the result is ≤ 2^CW-1 with no clipping needed.
  - mode 3: max.
- Stage 3:
  - mode 2: output all-ones if luma ≥ threshold, else 0.
  - other modes: pass the stage-2 value through.
- pix_count increments on each input transfer and holds at 2^PIX_CNT_W-1.
- Simultaneous load and drain in one stage (upstream valid, downstream taking): the new data replaces the old in the same cycle, with no bubble.
- Reset asserted mid-stream: all in-flight pixels are discarded immediately and m_valid falls asynchronously. No partial line is flushed afterwards.

Decomposition:
- Shared package gray_pkg holds:
  - mode encodings MODE_AVG = 0, MODE_LUMA = 1, MODE_THRESH = 2, MODE_MAX = 3.
  - luma coefficients KR = 77, KG = 150, KB = 29, and KSHIFT = 8.
  - a function returning the reciprocal constant and shift for divide-by-3 at a given CW.
- One sub-module: div3_const, a combinational exact floor(x/3) for a (CW+2)-bit x, instantiated in stage 2.
- Pipeline registers and handshake logic stay in the top level.

Test Plan:
- Mode 0, m_ready = 1, pixels 0xFFFFFF, 0x010203, 0x000002, 0x7F7F80 → m_gray 0xFF, 0x02, 0x00, 0x7F. Each appears exactly 3 cycles after acceptance, back-to-back.
- Mode 1, pixels 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF → 0x4C, 0x95, 0x1C, 0xFF.
- Mode 2, threshold 0x80, pixels 0x00FF00 then 0xFF0000 → 0xFF then 0x00. Change threshold to 0x40 on the cycle after the first pixel's acceptance and before the second's; the second still follows the threshold sampled at its own acceptance (0x40) → 0xFF.
- Backpressure: stream 6 pixels with s_last on pixel 6, and hold m_ready = 0 for 5 cycles after the first acceptance.
  - s_ready = 0 after 3 accepted.
  - m_gray holds stable while stalled.
  - After release, all 6 emerge in order, m_last only on the 6th, and pix_count = 6.
- Mode 3 exhaustive-edge check, CW = 8: 0x123456 → 0x56, 0x000000 → 0x00. Randomised 10k pixels across all modes match the reference model bit-exactly.
- Assert rst_n while 2 pixels are in flight → m_valid = 0 at once, pix_count = 0, and nothing is emitted after release until new input arrives. A separate counter run with PIX_CNT_W = 4 and 20 pixels → pix_count saturates at 15.
